sap1_ram_loader: RTL and testbench
==================================

// Module: sap1_ram_loader
// PURPOSE
//  Writer side of the SAP-1 16x8 program memory that the MAR reads. Accepts a byte
//  stream over a valid/ready handshake (from a serial receiver or switch front end)
//  and writes it sequentially to addresses 0..15. While loading, it holds the CPU
//  in clear. It flags completion, an inter-byte timeout, and an optional checksum error.
// PARAMETERS
//  ADDR_W          4     memory address width; image length = 2**ADDR_W bytes
//  DATA_W          8     memory word width
//  TIMEOUT_CYCLES  1024  max idle CLK cycles between accepted bytes; 0 = timeout disabled
// PORTS
//  CLK        in   1       system clock; all logic on rising edge
//  CLR_bar    in   1       reset, synchronous, active-low
//  start      in   1       1-cycle pulse: begin/restart a load
//  in_data    in   DATA_W  stream byte
//  in_valid   in   1       in_data valid
//  in_ready   out  1       loader can accept; transfer = in_valid & in_ready
//  mem_we     out  1       1-cycle memory write strobe
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  DATA_W  write data
//  cpu_hold   out  1       high = CPU must be held in clear
//  done       out  1       image loaded successfully (level)
//  error      out  1       load failed: timeout or checksum (level)
// BEHAVIOUR
//  - Reset (CLR_bar=0 at edge): state IDLE. All outputs are 0: in_ready, mem_we,
//    mem_addr, mem_wdata, cpu_hold, done and error. Address counter, timer and sum are 0.
//  - States: IDLE, LOAD, CHECK (CHECKSUM_EN only), DONE, ERROR. All outputs are registered.
//  - Any state, start=1 -> LOAD next cycle. On entry: addr=0, sum=0, timer=0, done=0,
//    error=0, cpu_hold=1. start has priority over a same-cycle transfer; that byte
//    is consumed and discarded.
//  - LOAD: in_ready=1. On a transfer of byte at address a, in the next cycle:
//    mem_we=1, mem_addr=a, mem_wdata=byte; sum+=byte (mod 2**DATA_W); addr=a+1.
//    Latency from transfer to write strobe is 1 cycle. Back-to-back transfers give
//    a write every cycle. mem_addr/mem_wdata hold their last values when mem_we=0.
//  - Transfer at addr = 2**ADDR_W-1 (last byte): next state DONE, or CHECK with
//    CHECKSUM_EN. The address counter never wraps within a load.
//  - Timer: counts cycles in LOAD/CHECK with no transfer; cleared on each transfer.
//    When it reaches TIMEOUT_CYCLES-1 with no transfer -> ERROR.
//  - DONE: done=1, cpu_hold=0, in_ready=0. Holds until start or reset.
//  - ERROR: error=1, cpu_hold stays 1, in_ready=0. Holds until start or reset.
//  - IDLE after reset: cpu_hold=0, in_ready=0. A transfer attempt outside LOAD/CHECK is ignored.
//  - Reset mid-load: immediate return to IDLE. Partially written memory is left as is.
// CONFIGURATION
//  CHECKSUM_EN defined: after the 16th byte, enter CHECK with in_ready=1. The next
//   transferred byte is compared to the 8-bit modular sum of the 16 image bytes:
//   equal -> DONE, unequal -> ERROR. No mem_we is issued for the checksum byte.
//   The timeout applies in CHECK.
//  CHECKSUM_EN undefined: no CHECK state and no sum register. The last data byte -> DONE.
// STRUCTURE
//  - Shared package sap1_pkg: SAP1_ADDR_W=4, SAP1_DATA_W=8 constants,
//    loader_state_t enum {LD_IDLE, LD_LOAD, LD_CHECK, LD_DONE, LD_ERROR}.
//  - One sub-module: sap1_idle_timer. It is a resettable down-counter with clear and
//    expire ports, parameterised by TIMEOUT_CYCLES.
//  - The FSM, address counter and write register live in sap1_ram_loader.
// TESTING
//  1 Reset: hold CLR_bar=0 for 3 cycles -> all outputs 0 and state IDLE; in_valid=1 in IDLE -> no mem_we.
//  2 Full load: start, then 16 back-to-back bytes 0x10..0x1F -> 16 consecutive mem_we,
//    addr 0..15 with data 0x10..0x1F, 1 cycle after each transfer. done=1 and
//    cpu_hold=0 (without CHECKSUM_EN).
//  3 Backpressure gaps: 16 bytes with 5-cycle gaps and TIMEOUT_CYCLES=8 -> no error;
//    a 20-cycle gap after byte 3 -> error=1, cpu_hold=1, only addresses 0..2 written.
//  4 Restart: start pulse after byte 6, together with a valid byte -> that byte
//    dropped, the next byte written to addr 0.
//  5 CHECKSUM_EN: bytes 0x01 x16 then 0x10 -> done=1. Same image then 0x11 ->
//    error=1; no mem_we for the checksum byte.
//  6 Reset asserted mid-load at addr 9 -> next cycle all outputs 0. A new start reloads from addr 0.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants and the RAM loader state encoding.
package sap1_pkg;

    localparam int unsigned SAP1_ADDR_W = 4;
    localparam int unsigned SAP1_DATA_W = 8;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

endpackage

// File: rtl/sap1_idle_timer.sv
// Inter-byte idle timer: reloads on clear, counts down while enabled, flags expiry at zero.
module sap1_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RELOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= CW'(RELOAD);
        end else if (clear) begin
            count <= CW'(RELOAD);
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A zero count means TIMEOUT_CYCLES-1 idle cycles have already elapsed.
    assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == '0);

endmodule

// File: rtl/sap1_ram_loader.sv
// SAP-1 program memory writer: streams 2**ADDR_W bytes into RAM while holding the CPU in clear.
// Optional trailing checksum byte enabled by defining CHECKSUM_EN.
module sap1_ram_loader
    import sap1_pkg::*;
#(
    parameter int unsigned ADDR_W         = SAP1_ADDR_W,
    parameter int unsigned DATA_W         = SAP1_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              CLR_bar,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic              xfer;
    logic              ld_active;
    logic              expire;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    assign xfer      = in_valid && in_ready;
    assign ld_active = (state == LD_LOAD) || (state == LD_CHECK);

    sap1_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (CLK),
        .rst_n (CLR_bar),
        .clear (start || xfer || !ld_active),
        .enable(ld_active),
        .expire(expire)
    );

    always_ff @(posedge CLK) begin
        if (!CLR_bar) begin
            state     <= LD_IDLE;
            addr      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            // start wins over a same-cycle transfer; that byte is simply dropped.
            if (start) begin
                state    <= LD_LOAD;
                addr     <= '0;
                in_ready <= 1'b1;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
`ifdef CHECKSUM_EN
                sum      <= '0;
`endif
            end else begin
                case (state)
                    LD_LOAD: begin
                        if (xfer) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= in_data;
`ifdef CHECKSUM_EN
                            sum       <= sum + in_data;
`endif
                            if (addr == '1) begin
`ifdef CHECKSUM_EN
                                state    <= LD_CHECK;
`else
                                state    <= LD_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                                in_ready <= 1'b0;
`endif
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end else if (expire) begin
                            state    <= LD_ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
`ifdef CHECKSUM_EN
                    LD_CHECK: begin
                        if (xfer) begin
                            in_ready <= 1'b0;
                            if (in_data == sum) begin
                                state    <= LD_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state <= LD_ERROR;
                                error <= 1'b1;
                            end
                        end else if (expire) begin
                            state    <= LD_ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap1_ram_loader.sv
// Self-checking bench for sap1_ram_loader; define CHECKSUM_EN to also cover the checksum build.
module tb_sap1_ram_loader;

    logic       CLK = 1'b0;
    logic       CLR_bar;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       error;

    always #5 CLK = ~CLK;

    sap1_ram_loader #(
        .ADDR_W(4),
        .DATA_W(8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK      (CLK),
        .CLR_bar  (CLR_bar),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t        sbq[$];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;

    // Reference model: 0 idle, 1 load, 2 check, 3 done, 4 error
    int         m_ph   = 0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_sum  = '0;

    // One clock: every write strobe is popped from the scoreboard and checked.
    task automatic step();
        wr_t w;
        @(posedge CLK);
        #1;
        cyc++;
        if (mem_we === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h at cyc=%0d, required no write", mem_addr, mem_wdata, cyc);
            end else begin
                w = sbq.pop_front();
                if (mem_addr !== w.a || mem_wdata !== w.d || cyc !== w.c) begin
                    bad++;
                    $display("FAIL wr: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             mem_addr, mem_wdata, cyc, w.a, w.d, w.c);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].c <= cyc) begin
            total++;
            bad++;
            w = sbq.pop_front();
            $display("FAIL wr_missing: got no write at cyc=%0d, required addr=%0d data=%h", cyc, w.a, w.d);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulse_start();
        start  = 1'b1;
        m_ph   = 1;
        m_addr = '0;
        m_sum  = '0;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        wr_t w;
        in_valid = 1'b1;
        in_data  = d;
        if (m_ph == 1) begin
            w.a = m_addr;
            w.d = d;
            w.c = cyc + 1;
            sbq.push_back(w);
            m_sum = m_sum + d;
`ifdef CHECKSUM_EN
            if (m_addr == 4'hF) m_ph = 2;
`else
            if (m_addr == 4'hF) m_ph = 3;
`endif
            else m_addr = m_addr + 4'd1;
        end else if (m_ph == 2) begin
            m_ph = (d == m_sum) ? 3 : 4;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_trailer();
`ifdef CHECKSUM_EN
        send(m_sum);
`endif
    endtask

    task automatic test_reset();
        CLR_bar = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge CLK);
        repeat (3) step();
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b, required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
        end
        CLR_bar  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL idle_ignore: got we=%b rdy=%b, required we=0 rdy=0", mem_we, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_load();
        pulse_start();
        total++;
        if ({cpu_hold, in_ready, done, error} !== 4'b1100) begin
            bad++;
            $display("FAIL load_entry: got hold/rdy/done/err=%b, required 1100", {cpu_hold, in_ready, done, error});
        end
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        send_trailer();
        total++;
        if ({done, cpu_hold, in_ready, error} !== 4'b1000) begin
            bad++;
            $display("FAIL full_done: got done/hold/rdy/err=%b, required 1000", {done, cpu_hold, in_ready, error});
        end
        idle(2);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL full_pending: got %0d writes outstanding, required 0", sbq.size());
        end
    endtask

    task automatic test_gaps();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i != 0) idle((i == 8) ? 7 : 5);
            send(8'h40 + 8'(i));
        end
        idle(5);
        send_trailer();
        total++;
        if ({done, error} !== 2'b10) begin
            bad++;
            $display("FAIL gaps_done: got done/err=%b, required 10", {done, error});
        end
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'h70 + 8'(i));
        idle(7);
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got err=%b, required 0", error);
        end
        step();
        total++;
        if ({error, cpu_hold, in_ready, done} !== 4'b1100) begin
            bad++;
            $display("FAIL timeout: got err/hold/rdy/done=%b, required 1100", {error, cpu_hold, in_ready, done});
        end
        m_ph = 4;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (12) step();
        in_valid = 1'b0;
        total++;
        if (error !== 1'b1 || sbq.size() != 0) begin
            bad++;
            $display("FAIL timeout_hold: got err=%b pending=%0d, required err=1 pending=0", error, sbq.size());
        end
    endtask

    task automatic test_restart();
        pulse_start();
        for (int i = 0; i < 6; i++) send(8'h80 + 8'(i));
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h86;
        m_ph = 1; m_addr = '0; m_sum = '0;
        step();
        start = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i));
        send_trailer();
        total++;
        if ({done, cpu_hold, error} !== 3'b100) begin
            bad++;
            $display("FAIL restart_done: got done/hold/err=%b, required 100", {done, cpu_hold, error});
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        for (int i = 0; i < 9; i++) send(8'h20 + 8'(i));
        CLR_bar  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        m_ph = 0;
        step();
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== 17'd0) begin
            bad++;
            $display("FAIL midreset: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b, required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
        end
        CLR_bar  = 1'b1;
        in_valid = 1'b0;
        idle(2);
        pulse_start();
        for (int i = 0; i < 16; i++) send(8'h90 + 8'(i));
        send_trailer();
        total++;
        if ({done, cpu_hold, error} !== 3'b100) begin
            bad++;
            $display("FAIL reload_done: got done/hold/err=%b, required 100", {done, cpu_hold, error});
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        for (int i = 0; i < 16; i++) send(8'h01);
        total++;
        if ({in_ready, done, error, cpu_hold} !== 4'b1001) begin
            bad++;
            $display("FAIL check_state: got rdy/done/err/hold=%b, required 1001", {in_ready, done, error, cpu_hold});
        end
        send(8'h10);
        total++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            bad++;
            $display("FAIL cksum_good: got done/err/hold=%b, required 100", {done, error, cpu_hold});
        end
        pulse_start();
        for (int i = 0; i < 16; i++) send(8'h01);
        send(8'h11);
        idle(2);
        total++;
        if ({done, error, cpu_hold} !== 3'b011 || sbq.size() != 0) begin
            bad++;
            $display("FAIL cksum_bad: got done/err/hold=%b pending=%0d, required 011 pending=0",
                     {done, error, cpu_hold}, sbq.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_restart();
        test_reset_mid_load();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
